// File: rtl/alu_pkg.sv
// alu_pkg: shared types, frame layout, error-byte constants and the result predictor
// Used by alu_result_checker, alu_exp_fifo's user and the testbench model.
package alu_pkg;
  typedef enum logic [2:0] {and_op, or_op, add_op, sub_op, data_error, crc_error, op_error} operation_t;
  typedef enum logic [1:0] {IDLE, SHIFT, STOP} rx_state_t;
  localparam int TYPE_POS = 8;
  localparam int ERR_POS = 7;
  localparam int FLG_HI = 6;
  localparam int FLG_LO = 3;
  localparam logic [3:0] SHIFT_LAST = 4'd8;
  localparam logic [7:0] ERR_DATA = 8'hC9;
  localparam logic [7:0] ERR_CRC = 8'hA5;
  localparam logic [7:0] ERR_OP = 8'h93;
  typedef struct packed {
    logic        is_err;
    logic [63:0] result;
    logic [3:0]  flags;
    logic [7:0]  err_byte;
  } pred_t;
  // Operands are zero-extended to 64 bits; w is the live width. Flags are {C,V,Z,N}.
  function automatic pred_t alu_predict(input operation_t op, input logic [63:0] a, input logic [63:0] b, input int unsigned w);
    logic [64:0] s;
    logic [63:0] m, r;
    logic [5:0] hi;
    logic [6:0] wi;
    logic c, v, e;
    pred_t p;
    hi = 6'(w - 1);
    wi = 7'(w);
    m = (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
    s = (op == add_op) ? {1'b0, a} + {1'b0, b} :
        (op == sub_op) ? {1'b0, b} - {1'b0, a} :
        {1'b0, (op == and_op) ? (a & b) : (a | b)};
    r = s[63:0] & m;
    c = (op == add_op) ? s[wi] : (op == sub_op) && (b < a);
    v = (op == add_op) ? (a[hi] == b[hi]) && (r[hi] != a[hi]) :
        (op == sub_op) && (a[hi] != b[hi]) && (r[hi] != b[hi]);
    e = op inside {data_error, crc_error, op_error};
    p.is_err = e;
    p.result = e ? '0 : r;
    p.flags = e ? 4'b0000 : {c, v, r == 64'd0, r[hi]};
    p.err_byte = (op == data_error) ? ERR_DATA : (op == crc_error) ? ERR_CRC : (op == op_error) ? ERR_OP : 8'h00;
    return p;
  endfunction
endpackage

// File: rtl/alu_exp_fifo.sv
// alu_exp_fifo: expected-transaction queue with occupancy output
// push_i/din_i write, pop_i/dout_o read head, full_o/empty_o status, level_o occupancy.
// A push while full is accepted only when a pop happens in the same cycle.
module alu_exp_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] lvl_q;
  logic do_push, do_pop;
  assign full_o = lvl_q == LW'(DEPTH);
  assign empty_o = lvl_q == '0;
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o = mem[rd_q];
  assign level_o = lvl_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
    end else begin
      wr_q <= do_push ? wr_q + AW'(1) : wr_q;
      rd_q <= do_pop ? rd_q + AW'(1) : rd_q;
      lvl_q <= lvl_q + LW'(do_push) - LW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din_i;
  end
endmodule

// File: rtl/alu_result_checker.sv
// alu_result_checker: predicts ALU results at push, deserialises sout responses and judges them
// exp_*: expected-transaction push; sout: serial response line (idle high)
// chk_done/chk_fail: judgement pulse; dut_result/dut_flags: last normal response
// pass_cnt/fail_cnt: saturating counters; q_level: queue occupancy
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   exp_valid,
  output logic                   exp_ready,
  input  operation_t             exp_op,
  input  logic [DATA_W-1:0]      exp_a,
  input  logic [DATA_W-1:0]      exp_b,
  input  logic                   sout,
  output logic                   chk_done,
  output logic                   chk_fail,
  output logic [DATA_W-1:0]      dut_result,
  output logic [3:0]             dut_flags,
  output logic [CNT_W-1:0]       pass_cnt,
  output logic [CNT_W-1:0]       fail_cnt,
  output logic [$clog2(DEPTH):0] q_level
);
  localparam logic [3:0] NB4 = 4'(DATA_W / 8);
  localparam int EW = DATA_W + 13;
  rx_state_t state_q, state_d;
  logic [3:0] bit_q, bit_d, cnt_q, cnt_d, rcnt_q, rcnt_d;
  logic [8:0] sh_q, sh_d;
  logic [7:0] rbyte_q, rbyte_d;
  logic [DATA_W-1:0] acc_q, acc_d, res_q, res_d;
  logic [3:0] flg_q, flg_d;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
  logic armed_q, armed_d, pend_q, pend_d, bad_q, bad_d, rerr_q, rerr_d;
  logic full, empty, pop, ok;
  logic [EW-1:0] din, head;
  pred_t pred;
  assign pred = alu_predict(exp_op, 64'(exp_a), 64'(exp_b), DATA_W);
  assign din = {pred.is_err, pred.result[DATA_W-1:0], pred.flags, pred.err_byte};
  if (DATA_W < 64) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^pred.result[63:DATA_W];
  end
  alu_exp_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(exp_valid & exp_ready),
    .pop_i(pop),
    .din_i(din),
    .dout_o(head),
    .full_o(full),
    .empty_o(empty),
    .level_o(q_level)
  );
  // The judgement cycle frees a slot, so a push is taken even when full.
  assign exp_ready = ~full | pop;
  assign pop = pend_q & ~empty;
  assign ok = ~empty & ~bad_q & (rerr_q == head[EW-1]) &
              (head[EW-1] ? (rcnt_q == 4'd0) && (rbyte_q == head[7:0]) :
                            (rcnt_q == NB4) && (res_q == head[EW-2 -: DATA_W]) && (flg_q == head[11:8]));
  assign chk_done = pend_q;
  assign chk_fail = pend_q & ~ok;
  assign dut_result = res_q;
  assign dut_flags = flg_q;
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    sh_d = sh_q;
    armed_d = armed_q | sout;
    acc_d = acc_q;
    cnt_d = cnt_q;
    pend_d = 1'b0;
    bad_d = bad_q;
    rerr_d = rerr_q;
    rcnt_d = rcnt_q;
    rbyte_d = rbyte_q;
    res_d = res_q;
    flg_d = flg_q;
    pass_d = (pend_q & ok & ~&pass_q) ? pass_q + CNT_W'(1) : pass_q;
    fail_d = (pend_q & ~ok & ~&fail_q) ? fail_q + CNT_W'(1) : fail_q;
    case (state_q)
      IDLE: begin
        // A start bit is only trusted once the line has been seen idle.
        if (armed_q && !sout) begin
          state_d = SHIFT;
          bit_d = 4'd0;
        end
      end
      SHIFT: begin
        sh_d = {sh_q[7:0], sout};
        bit_d = bit_q + 4'd1;
        state_d = (bit_q == SHIFT_LAST) ? STOP : SHIFT;
      end
      STOP: begin
        state_d = IDLE;
        if (!sout || (!sh_q[TYPE_POS] && cnt_q == NB4)) begin
          pend_d = 1'b1;
          bad_d = 1'b1;
          acc_d = '0;
          cnt_d = 4'd0;
          armed_d = sout;
        end else if (sh_q[TYPE_POS]) begin
          pend_d = 1'b1;
          bad_d = 1'b0;
          rerr_d = sh_q[ERR_POS];
          rcnt_d = cnt_q;
          rbyte_d = sh_q[7:0];
          res_d = sh_q[ERR_POS] ? res_q : acc_q;
          flg_d = sh_q[ERR_POS] ? flg_q : sh_q[FLG_HI:FLG_LO];
          acc_d = '0;
          cnt_d = 4'd0;
        end else begin
          acc_d = (acc_q << 8) | DATA_W'(sh_q[7:0]);
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q <= '0;
      sh_q <= '0;
      armed_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      pend_q <= 1'b0;
      bad_q <= 1'b0;
      rerr_q <= 1'b0;
      rcnt_q <= '0;
      rbyte_q <= '0;
      res_q <= '0;
      flg_q <= '0;
      pass_q <= '0;
      fail_q <= '0;
    end else begin
      state_q <= state_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      armed_q <= armed_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      bad_q <= bad_d;
      rerr_q <= rerr_d;
      rcnt_q <= rcnt_d;
      rbyte_q <= rbyte_d;
      res_q <= res_d;
      flg_q <= flg_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end
endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker: directed self-checking bench for a 32-bit and a 16-bit checker
module tb_alu_result_checker;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v32 = 1'b0, s32 = 1'b1, r32, d32, f32;
  operation_t op32 = and_op;
  logic [31:0] a32 = '0, b32 = '0, res32;
  logic [3:0] flg32, lv32;
  logic [15:0] pc32, fc32;
  logic v16 = 1'b0, s16 = 1'b1, r16, d16, f16;
  operation_t op16 = and_op;
  logic [15:0] a16 = '0, b16 = '0, res16;
  logic [3:0] flg16;
  logic [1:0] pc16, fc16, lv16;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  alu_result_checker #(.DATA_W(32), .DEPTH(8), .CNT_W(16)) u32 (
    .clk(clk), .rst(rst), .exp_valid(v32), .exp_ready(r32), .exp_op(op32), .exp_a(a32), .exp_b(b32),
    .sout(s32), .chk_done(d32), .chk_fail(f32), .dut_result(res32), .dut_flags(flg32),
    .pass_cnt(pc32), .fail_cnt(fc32), .q_level(lv32)
  );
  alu_result_checker #(.DATA_W(16), .DEPTH(2), .CNT_W(2)) u16 (
    .clk(clk), .rst(rst), .exp_valid(v16), .exp_ready(r16), .exp_op(op16), .exp_a(a16), .exp_b(b16),
    .sout(s16), .chk_done(d16), .chk_fail(f16), .dut_result(res16), .dut_flags(flg16),
    .pass_cnt(pc16), .fail_cnt(fc16), .q_level(lv16)
  );
  task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask
  task automatic drv(input bit w, input logic v);
    if (w) s16 = v;
    else s32 = v;
  endtask
  task automatic frame(input bit w, input logic t, input logic [7:0] d, input logic stp);
    logic [10:0] f;
    f = {1'b0, t, d, stp};
    for (int i = 10; i >= 0; i--) begin
      drv(w, f[i]);
      @(negedge clk);
    end
    drv(w, 1'b1);
  endtask
  task automatic resp(input bit w, input logic [31:0] val, input int nb, input logic [3:0] fl);
    for (int k = 0; k < nb; k++) frame(w, 1'b0, val[8*(nb-1-k) +: 8], 1'b1);
    frame(w, 1'b1, {1'b0, fl, 3'b101}, 1'b1);
  endtask
  task automatic push(input bit w, input operation_t op, input logic [31:0] a, input logic [31:0] b);
    if (w) begin
      v16 = 1'b1; op16 = op; a16 = a[15:0]; b16 = b[15:0];
    end else begin
      v32 = 1'b1; op32 = op; a32 = a; b32 = b;
    end
    @(negedge clk);
    v16 = 1'b0;
    v32 = 1'b0;
  endtask
  task automatic judge(input string t, input bit w, input logic ef, input int pc, input int fc, input int lv);
    chk({t, "_done"}, w ? d16 : d32, 1);
    chk({t, "_fail"}, w ? f16 : f32, ef);
    @(negedge clk);
    chk({t, "_pulse"}, w ? d16 : d32, 0);
    chk({t, "_pass"}, w ? 16'(pc16) : pc32, pc);
    chk({t, "_failcnt"}, w ? 16'(fc16) : fc32, fc);
    chk({t, "_level"}, w ? 4'(lv16) : lv32, lv);
  endtask
  initial begin
    pred_t p;
    repeat (2) @(negedge clk);
    chk("rst_ready", r32, 1);
    chk("rst_level", lv32, 0);
    chk("rst_done", d32, 0);
    chk("rst_fail", f32, 0);
    chk("rst_res", res32, 0);
    chk("rst_flg", flg32, 0);
    chk("rst_pass", pc32, 0);
    chk("rst_failcnt", fc32, 0);
    rst = 1'b0;
    @(negedge clk);
    p = alu_predict(sub_op, 64'd5, 64'd3, 32);
    chk("pred_sub_res", p.result, 64'hFFFF_FFFE);
    chk("pred_sub_flg", p.flags, 4'b1001);
    p = alu_predict(add_op, 64'hFFFF, 64'd1, 16);
    chk("pred_add16", {p.result[15:0], p.flags}, 20'h0000A);
    push(0, add_op, 32'hFFFF_FFFF, 32'h1);
    chk("add_push_level", lv32, 1);
    resp(0, 32'h0, 4, 4'b1010);
    judge("add_carry", 0, 0, 1, 0, 0);
    chk("add_res", res32, 0);
    chk("add_flg", flg32, 4'b1010);
    push(0, sub_op, 32'd5, 32'd3);
    resp(0, 32'hFFFF_FFFE, 4, 4'b1001);
    judge("sub_ok", 0, 0, 2, 0, 0);
    push(0, sub_op, 32'd5, 32'd3);
    resp(0, 32'hFFFF_FFFE, 4, 4'b0000);
    judge("sub_badflg", 0, 1, 2, 1, 0);
    push(0, op_error, 32'd0, 32'd0);
    chk("operr_level", lv32, 1);
    resp(0, 32'h0, 4, 4'b0000);
    judge("operr_vs_norm", 0, 1, 2, 2, 0);
    push(0, crc_error, 32'd0, 32'd0);
    frame(0, 1'b1, ERR_CRC, 1'b1);
    judge("crc_err_ok", 0, 0, 3, 2, 0);
    push(0, data_error, 32'd0, 32'd0);
    frame(0, 1'b1, ERR_OP, 1'b1);
    judge("data_err_bad", 0, 1, 3, 3, 0);
    push(0, and_op, 32'hF0F0_F0F0, 32'hFF00_FF00);
    resp(0, 32'hF000_F000, 4, 4'b0001);
    judge("and", 0, 0, 4, 3, 0);
    push(0, or_op, 32'd0, 32'd0);
    resp(0, 32'h0, 4, 4'b0010);
    judge("or_zero", 0, 0, 5, 3, 0);
    push(0, add_op, 32'h7FFF_FFFF, 32'h1);
    resp(0, 32'h8000_0000, 4, 4'b0101);
    judge("add_ovf", 0, 0, 6, 3, 0);
    for (int i = 0; i < 8; i++) push(0, add_op, 32'd1, 32'd1);
    chk("full_level", lv32, 8);
    chk("full_ready", r32, 0);
    push(0, add_op, 32'd9, 32'd9);
    chk("full_push_ignored", lv32, 8);
    resp(0, 32'd2, 4, 4'b0000);
    chk("full_done", d32, 1);
    chk("full_fail", f32, 0);
    chk("full_ready_on_pop", r32, 1);
    push(0, add_op, 32'd3, 32'd3);
    chk("full_level_kept", lv32, 8);
    chk("full_pass", pc32, 7);
    for (int i = 0; i < 7; i++) begin
      resp(0, 32'd2, 4, 4'b0000);
      judge("drain", 0, 0, 8 + i, 3, 7 - i);
    end
    resp(0, 32'd6, 4, 4'b0000);
    judge("drain_last", 0, 0, 15, 3, 0);
    push(0, add_op, 32'd1, 32'd2);
    push(0, add_op, 32'd2, 32'd2);
    chk("stop0_level", lv32, 2);
    frame(0, 1'b0, 8'h00, 1'b1);
    frame(0, 1'b0, 8'h00, 1'b0);
    judge("stop0", 0, 1, 15, 4, 1);
    resp(0, 32'd4, 4, 4'b0000);
    judge("after_stop0", 0, 0, 16, 4, 0);
    push(0, add_op, 32'd1, 32'd1);
    for (int i = 0; i < 5; i++) frame(0, 1'b0, 8'h00, 1'b1);
    judge("too_many_data", 0, 1, 16, 5, 0);
    resp(0, 32'h1234_5678, 4, 4'b0000);
    judge("empty_queue", 0, 1, 16, 6, 0);
    chk("empty_queue_res", res32, 32'h1234_5678);
    push(0, add_op, 32'd1, 32'd1);
    chk("pre_rst_level", lv32, 1);
    drv(0, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_level", lv32, 0);
    chk("midrst_ready", r32, 1);
    chk("midrst_done", d32, 0);
    chk("midrst_fail", f32, 0);
    chk("midrst_res", res32, 0);
    chk("midrst_pass", pc32, 0);
    chk("midrst_failcnt", fc32, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    chk("low_after_rst_failcnt", fc32, 0);
    chk("low_after_rst_level", lv32, 0);
    drv(0, 1'b1);
    repeat (2) @(negedge clk);
    resp(0, 32'h0, 4, 4'b0000);
    judge("post_rst_empty", 0, 1, 0, 1, 0);
    push(1, add_op, 32'hFFFF, 32'h1);
    resp(1, 32'h0, 2, 4'b1010);
    judge("w16_add", 1, 0, 1, 0, 0);
    chk("w16_res", res16, 0);
    chk("w16_flg", flg16, 4'b1010);
    push(1, or_op, 32'd0, 32'd0);
    push(1, or_op, 32'd0, 32'd0);
    chk("w16_full_level", lv16, 2);
    chk("w16_full_ready", r16, 0);
    resp(1, 32'h0, 2, 4'b0010);
    judge("w16_or1", 1, 0, 2, 0, 1);
    resp(1, 32'h0, 2, 4'b0010);
    judge("w16_or2", 1, 0, 3, 0, 0);
    push(1, or_op, 32'd0, 32'd0);
    resp(1, 32'h0, 2, 4'b0010);
    judge("w16_sat", 1, 0, 3, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_result_checker.md
ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

Interface
REQ-001 Parameter DATA_W, default 32; operand/result width, SHALL be a multiple of 8, range 8..64.
REQ-002 Parameter DEPTH, default 8; expected-transaction queue depth, power of two, >=2.
REQ-003 Parameter CNT_W, default 16; width of pass/fail counters.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 exp_valid  in  1  expected transaction offered.
REQ-007 exp_ready  out  1  queue not full; push occurs when exp_valid && exp_ready.
REQ-008 exp_op  in  operation_t  and_op, or_op, add_op, sub_op, data_error, crc_error, op_error.
REQ-009 exp_a, exp_b  in  DATA_W each  operands A and B.
REQ-010 sout  in  1  ALU serial response line, one bit per clk, idle high.
REQ-011 chk_done  out  1  one-cycle pulse when a response is judged.
REQ-012 chk_fail  out  1  valid with chk_done; 1 = mismatch, framing error or unexpected response.
REQ-013 dut_result  out  DATA_W  last received result; dut_flags  out  4  last received flags {C,V,Z,N}.
REQ-014 pass_cnt, fail_cnt  out  CNT_W each  saturating judgement counters.
REQ-015 q_level  out  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-016 Prediction SHALL be computed combinationally at push and stored in the queue as {is_err, result, flags, err_byte}.
REQ-017 Predicted result: and A&B, or A|B, add A+B, sub B-A, all modulo 2^DATA_W.
REQ-018 Flags: Z = result==0; N = result MSB; C = carry-out of add, or borrow (B<A unsigned) for sub, else 0; V = signed overflow of add/sub, else 0.
REQ-019 Error ops SHALL set is_err and err_byte to the package constant for that op; result/flags ignored.
REQ-020 Frame = 11 bits: start 0, type bit (0 data, 1 control), 8 data bits MSB first, stop 1.
REQ-021 Deserialiser FSM states IDLE, SHIFT, STOP; IDLE->SHIFT on sout==0; SHIFT counts 9 bits; STOP samples the stop bit, then IDLE.
REQ-022 Stop bit 0 SHALL be a framing error: judge fail, discard partial response, pop one queue entry if non-empty.
REQ-023 Data frames SHALL be assembled MSB-byte first into dut_result; more than DATA_W/8 data frames before a control frame is a framing error.
REQ-024 Normal response = DATA_W/8 data frames + control frame {0, flags[3:0], crc[2:0]}; CRC is not checked.
REQ-025 Error response = single control frame {1, err[5:0], parity}, compared whole against err_byte.
REQ-026 On control frame: pop head, compare; pass iff type of response matches is_err, data-frame count matches, and result+flags (or err byte) equal.
REQ-027 chk_done SHALL assert the cycle after the control-frame stop bit is sampled; latency from push to judgement is otherwise unbounded.
REQ-028 Response with empty queue SHALL be judged fail with no pop.
REQ-029 Push and pop in the same cycle SHALL both occur, level unchanged; push when full is ignored (exp_ready=0).
REQ-030 Counters SHALL saturate at all-ones, never wrap.

Reset
REQ-031 rst SHALL immediately force: FSM IDLE, queue empty, exp_ready 1, q_level 0, chk_done 0, chk_fail 0, dut_result 0, dut_flags 0, pass_cnt 0, fail_cnt 0.
REQ-032 Reset mid-frame SHALL discard the partial frame; a sout still low after reset release SHALL NOT be taken as a start bit until sout has been seen high.

Structure
REQ-033 operation_t, frame field positions, and the three err_byte constants SHALL live in alu_pkg.
REQ-034 The queue SHALL be one sub-module, alu_exp_fifo, parametrised by width and DEPTH, with level output.
REQ-035 Prediction logic SHALL be a function in alu_pkg, reused by the testbench model.

Verification
REQ-036 add_op A=32'hFFFFFFFF B=32'h1, correct response result 0 flags C=1,Z=1 -> chk_done, chk_fail=0, pass_cnt=1.
REQ-037 sub_op A=5 B=3, response result 32'hFFFFFFFE flags C=1,N=1 -> pass; same with flags 4'b0000 -> chk_fail=1, fail_cnt=1.
REQ-038 op_error pushed, ALU returns normal 5-frame response -> fail, queue level 1->0.
REQ-039 DEPTH pushes with no response -> exp_ready=0, q_level=DEPTH; extra push ignored; one response plus simultaneous push -> level stays DEPTH.
REQ-040 Stop bit forced 0 in 2nd data frame -> framing fail, entry popped, next correct response passes.
REQ-041 rst asserted mid-frame with sout low -> all outputs zero, subsequent response with empty queue -> fail, no underflow; DATA_W=16 variant repeats REQ-036 with 16'hFFFF+1.
